// File: rtl/zero_cross_freq_meter.sv
// Hysteretic zero-crossing frequency meter: averages PERIODS cycles and converts samples to Hz.
// Optional macro FREQ_IIR_EN smooths each new result as (3*freq + r) >> 2.
module zero_cross_freq_meter #(
    parameter int                 SAMPLE_RATE     = 48000,
    parameter int                 PERIODS         = 4,
    parameter logic signed [23:0] HYST            = 24'sh001000,
    parameter int                 TIMEOUT_SAMPLES = 4800
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               sample_valid,
    input  logic signed [23:0] sample,
    output logic [15:0]        freq,
    output logic               freq_valid,
    output logic               signal_lost,
    output logic               busy,
    output logic [1:0]         o_dbg_state
);

    localparam logic [1:0]         ST_UNARMED = 2'd0;
    localparam logic [1:0]         ST_LOW     = 2'd1;
    localparam logic [1:0]         ST_HIGH    = 2'd2;
    localparam int                 GAP_W      = $clog2(TIMEOUT_SAMPLES + 1);
    localparam logic [GAP_W-1:0]   GAP_MAX    = GAP_W'(TIMEOUT_SAMPLES);
    localparam logic [31:0]        NUM_BASE   = 32'(SAMPLE_RATE * PERIODS);
    localparam logic [3:0]         XING_LAST  = 4'(PERIODS);
    localparam logic signed [23:0] NEG_HYST   = -HYST;

    logic [1:0]       r_state;
    logic             r_open;
    logic [19:0]      r_cnt;
    logic [3:0]       r_xings;
    logic [GAP_W-1:0] r_gap;
    logic             r_busy;
    logic [5:0]       r_step;
    logic [19:0]      r_divisor;
    logic [31:0]      r_num;
    logic [19:0]      r_rem;
    logic             r_fin;
    logic [15:0]      r_freq;
    logic             r_freq_valid;
    logic             r_lost;

    logic        w_hi, w_lo, w_rise, w_close, w_start, w_timeout;
    logic [20:0] w_shift;
    logic        w_ge;
    logic [19:0] w_sub;
    logic [15:0] w_quot;
    logic [15:0] w_result;

    assign w_hi      = sample_valid && (sample >= HYST);
    assign w_lo      = sample_valid && (sample < NEG_HYST);
    assign w_rise    = (r_state == ST_LOW) && w_hi;
    assign w_timeout = (r_gap == GAP_MAX) && !r_busy;
    assign w_close   = w_rise && r_open && ((r_xings + 4'd1) == XING_LAST);
    assign w_start   = w_close && !r_busy && !w_timeout;

    // Detector: values inside [-HYST, +HYST) hold the current state.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_UNARMED;
        end else if (w_timeout) begin
            r_state <= ST_UNARMED;
        end else if (w_lo) begin
            r_state <= ST_LOW;
        end else if (w_rise) begin
            r_state <= ST_HIGH;
        end
    end

    // A closing crossing always reopens the window, whether or not the divider took it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_open  <= 1'b0;
            r_cnt   <= '0;
            r_xings <= '0;
            r_gap   <= '0;
        end else if (w_timeout) begin
            r_open  <= 1'b0;
            r_cnt   <= '0;
            r_xings <= '0;
            r_gap   <= '0;
        end else if (sample_valid) begin
            if (w_rise) begin
                r_gap <= '0;
                if (!r_open || w_close) begin
                    r_open  <= 1'b1;
                    r_cnt   <= 20'd1;
                    r_xings <= '0;
                end else begin
                    r_cnt   <= r_cnt + 20'd1;
                    r_xings <= r_xings + 4'd1;
                end
            end else begin
                r_cnt <= r_cnt + 20'd1;
                if (r_gap != GAP_MAX) begin
                    r_gap <= r_gap + 1'b1;
                end
            end
        end
    end

    assign w_shift = {r_rem, r_num[31]};
    assign w_ge    = (w_shift >= {1'b0, r_divisor});
    assign w_sub   = 20'(w_shift - {1'b0, r_divisor});

    // Step 0 loads the rounded numerator; steps 1..32 each resolve one quotient bit.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_busy    <= 1'b0;
            r_step    <= '0;
            r_divisor <= '0;
            r_num     <= '0;
            r_rem     <= '0;
            r_fin     <= 1'b0;
        end else begin
            r_fin <= r_busy && (r_step == 6'd32);
            if (w_start) begin
                r_busy    <= 1'b1;
                r_step    <= '0;
                r_divisor <= r_cnt;
            end else if (r_busy) begin
                if (r_step == 6'd0) begin
                    r_num <= NUM_BASE + {13'd0, r_divisor[19:1]};
                    r_rem <= '0;
                end else begin
                    r_num <= {r_num[30:0], w_ge};
                    r_rem <= w_ge ? w_sub : w_shift[19:0];
                end
                r_step <= r_step + 6'd1;
                if (r_step == 6'd32) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign w_quot = (r_num[31:16] != 16'd0) ? 16'hFFFF : r_num[15:0];

`ifdef FREQ_IIR_EN
    logic [17:0] w_acc;
    assign w_acc    = {2'b00, r_freq} + {1'b0, r_freq, 1'b0} + {2'b00, w_quot};
    assign w_result = r_lost ? w_quot : 16'(w_acc >> 2);
`else
    assign w_result = w_quot;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_freq       <= '0;
            r_freq_valid <= 1'b0;
            r_lost       <= 1'b1;
        end else if (w_timeout) begin
            r_freq       <= '0;
            r_freq_valid <= 1'b1;
            r_lost       <= 1'b1;
        end else if (r_fin) begin
            r_freq       <= w_result;
            r_freq_valid <= 1'b1;
            r_lost       <= 1'b0;
        end else begin
            r_freq_valid <= 1'b0;
        end
    end

    assign freq        = r_freq;
    assign freq_valid  = r_freq_valid;
    assign signal_lost = r_lost;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_zero_cross_freq_meter.sv
// Bench for zero_cross_freq_meter: table-driven square waves, hand sequences and random stimulus vs a sample-level model.
module tb_zero_cross_freq_meter;

    localparam int SR   = 48000;
    localparam int P    = 4;
    localparam int HYST = 4096;
    localparam int TO   = 4800;
    localparam int AMP  = 24'h100000;

    logic               clock = 1'b0;
    logic               resetn = 1'b0;
    logic               sample_valid = 1'b0;
    logic signed [23:0] sample = '0;
    logic [15:0]        freq;
    logic               freq_valid;
    logic               signal_lost;
    logic               busy;
    logic [1:0]         dbg_state;

    zero_cross_freq_meter u_dut (
        .clock        (clock),
        .resetn       (resetn),
        .sample_valid (sample_valid),
        .sample       (sample),
        .freq         (freq),
        .freq_valid   (freq_valid),
        .signal_lost  (signal_lost),
        .busy         (busy),
        .o_dbg_state  (dbg_state)
    );

    always #5 clock = ~clock;

    longint cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: each entry is {signal_lost, freq} expected at the next freq_valid.
    logic [16:0] exp_q[$];
    int          pulses = 0;
    longint      last_valid_cyc = 0;
    logic [15:0] last_freq = '0;

    always @(negedge clock) begin
        if (freq_valid === 1'b1) begin
            logic [16:0] e;
            pulses++;
            last_valid_cyc = cyc;
            last_freq      = freq;
            if (exp_q.size() == 0) begin
                check("pulse_was_expected", 0, 1);
            end else begin
                e = exp_q.pop_front();
                check("freq", longint'(freq), longint'(e[15:0]));
                check("signal_lost_at_pulse", longint'(signal_lost), longint'(e[16]));
            end
        end
    end

    // Reference model, evaluated once per accepted sample.
    int     m_state;
    bit     m_open;
    longint m_idx, m_open_idx, m_gap_ref, m_busy_start;
    int     m_xings;
    bit     m_lost;
    int     m_freq;
    int     m_pushed;
    longint last_cap = 0;

    task automatic model_reset();
        m_state      = 0;
        m_open       = 0;
        m_idx        = -1;
        m_open_idx   = 0;
        m_gap_ref    = -1;
        m_busy_start = -1000;
        m_xings      = 0;
        m_lost       = 1;
        m_freq       = 0;
        m_pushed     = 0;
        exp_q.delete();
    endtask

    task automatic model_result(input longint d);
        longint q;
        q = (d == 0) ? 65535 : (longint'(SR * P) + d / 2) / d;
        if (q > 65535) q = 65535;
`ifdef FREQ_IIR_EN
        if (!m_lost) q = (3 * m_freq + q) / 4;
`endif
        m_freq = int'(q);
        m_lost = 0;
        m_pushed++;
        exp_q.push_back({1'b0, 16'(q)});
    endtask

    task automatic model_sample(input longint t, input int s);
        bit rise;
        m_idx++;
        rise = (m_state == 1) && (s >= HYST);
        if (s < -HYST) m_state = 1;
        else if (rise) m_state = 2;
        if (rise) begin
            m_gap_ref = m_idx;
            if (!m_open) begin
                m_open     = 1;
                m_open_idx = m_idx;
                m_xings    = 0;
            end else begin
                m_xings++;
                if (m_xings == P) begin
                    if (!(t > m_busy_start && t <= m_busy_start + 33)) begin
                        model_result(m_idx - m_open_idx);
                        m_busy_start = t;
                    end
                    m_open_idx = m_idx;
                    m_xings    = 0;
                end
            end
        end
        if (m_idx - m_gap_ref == TO) begin
            m_pushed++;
            exp_q.push_back({1'b1, 16'd0});
            m_lost    = 1;
            m_freq    = 0;
            m_state   = 0;
            m_open    = 0;
            m_gap_ref = m_idx;
        end
    endtask

    // Called at a falling edge; the sample is captured on the next rising edge.
    task automatic drive(input int s, input int spacing);
        sample_valid = 1'b1;
        sample       = 24'(s);
        @(negedge clock);
        last_cap = cyc;
        model_sample(cyc, s);
        sample_valid = 1'b0;
        repeat (spacing - 1) @(negedge clock);
    endtask

    task automatic send_period(input int p, input int spacing);
        int hi;
        hi = p - p / 2;
        repeat (hi) drive(AMP, spacing);
        repeat (p - hi) drive(-AMP, spacing);
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn       = 1'b0;
        sample_valid = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        pulses = 0;
    endtask

    function automatic int rand_val(input bit high);
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0) return HYST;
        if (r == 1) return -HYST;
        if (r == 2) return -HYST - 1;
        if (r == 3) return HYST - 1;
        if (r <= 5) return int'($urandom_range(0, 8191)) - 4096;
        if (high) return int'($urandom_range(HYST, 8388607));
        return -int'($urandom_range(HYST + 1, 8388608));
    endfunction

    typedef struct {
        int          pa;
        int          pb;
        int          nwin;
        int          spacing;
        logic [15:0] exp_freq;
    } vec_t;

    vec_t vecs[6];

    initial begin
        // Watchdog keeps the run bounded even if the stimulus stalls.
        #4000000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_fail++;
        n_tests++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        longint t1;
        vecs[0] = '{pa: 48,  pb: 48,  nwin: 1, spacing: 4, exp_freq: 16'd1000};
        vecs[1] = '{pa: 109, pb: 110, nwin: 5, spacing: 4, exp_freq: 16'd438};
        vecs[2] = '{pa: 96,  pb: 96,  nwin: 2, spacing: 2, exp_freq: 16'd500};
        vecs[3] = '{pa: 40,  pb: 40,  nwin: 2, spacing: 1, exp_freq: 16'd1200};
        vecs[4] = '{pa: 30,  pb: 31,  nwin: 3, spacing: 3, exp_freq: 16'd1574};
        vecs[5] = '{pa: 2,   pb: 2,   nwin: 1, spacing: 2, exp_freq: 16'd24000};

        do_reset();
        check("reset_freq", longint'(freq), 0);
        check("reset_freq_valid", longint'(freq_valid), 0);
        check("reset_signal_lost", longint'(signal_lost), 1);
        check("reset_busy", longint'(busy), 0);
        check("reset_state", longint'(dbg_state), 0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            drive(-AMP, vecs[i].spacing);
            for (int k = 0; k < 4 * vecs[i].nwin; k++) begin
                send_period((k % 2 == 1) ? vecs[i].pb : vecs[i].pa, vecs[i].spacing);
            end
            drive(AMP, vecs[i].spacing);
            repeat (40) @(negedge clock);
            check($sformatf("row%0d_pulses", i), pulses, vecs[i].nwin);
            check($sformatf("row%0d_freq", i), longint'(last_freq), longint'(vecs[i].exp_freq));
            check($sformatf("row%0d_signal_lost", i), longint'(signal_lost), 0);
            check($sformatf("row%0d_latency", i), last_valid_cyc - last_cap, 34);
            check($sformatf("row%0d_queue_drained", i), exp_q.size(), 0);
        end

        // Second window closes while the divider is still busy and must be dropped.
        do_reset();
        drive(-AMP, 1);
        repeat (4) send_period(2, 1);
        drive(AMP, 1);
        t1 = last_cap;
        repeat (4) begin
            drive(-AMP, 1);
            drive(AMP, 1);
        end
        check("busy_at_second_close", longint'(busy), 1);
        repeat (60) @(negedge clock);
        check("busy_drop_pulses", pulses, 1);
        check("busy_drop_freq", longint'(last_freq), 24000);
        check("busy_drop_latency", last_valid_cyc - t1, 34);
        check("busy_drop_queue_drained", exp_q.size(), 0);

        // In-band sine: only the timeout produces a pulse.
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            drive(int'($rtoi(2048.0 * $sin(6.283185307 * i / 100.0))), 2);
        end
        repeat (5) @(negedge clock);
        check("timeout_pulses", pulses, 1);
        check("timeout_freq", longint'(freq), 0);
        check("timeout_signal_lost", longint'(signal_lost), 1);
        check("timeout_state", longint'(dbg_state), 0);
        check("timeout_queue_drained", exp_q.size(), 0);

        // Reset 10 clocks into a divide aborts it silently.
        do_reset();
        drive(-AMP, 4);
        repeat (4) send_period(48, 4);
        drive(AMP, 4);
        repeat (3) send_period(48, 4);
        send_period(47, 4);
        drive(-AMP, 4);
        drive(AMP, 1);
        repeat (9) @(negedge clock);
        check("pre_abort_busy", longint'(busy), 1);
        check("pre_abort_freq", longint'(freq), 1000);
        resetn = 1'b0;
        model_reset();
        #1;
        check("abort_busy", longint'(busy), 0);
        check("abort_freq", longint'(freq), 0);
        check("abort_signal_lost", longint'(signal_lost), 1);
        check("abort_freq_valid", longint'(freq_valid), 0);
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        pulses = 0;
        repeat (50) @(negedge clock);
        check("abort_no_pulse", pulses, 0);
        drive(-AMP, 4);
        repeat (4) send_period(48, 4);
        drive(AMP, 4);
        repeat (40) @(negedge clock);
        check("restart_pulses", pulses, 1);
        check("restart_freq", longint'(last_freq), 1000);
        check("restart_signal_lost", longint'(signal_lost), 0);

        // Random periods, spacing and boundary values against the model.
        do_reset();
        drive(-AMP, 1);
        for (int k = 0; k < 40; k++) begin
            int h;
            int l;
            h = int'($urandom_range(1, 60));
            l = int'($urandom_range(1, 60));
            repeat (h) drive(rand_val(1'b1), int'($urandom_range(1, 3)));
            repeat (l) drive(rand_val(1'b0), int'($urandom_range(1, 3)));
        end
        drive(AMP, 1);
        repeat (60) @(negedge clock);
        check("random_pulses", pulses, m_pushed);
        check("random_queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
